cmd_cfg_param: RTL and testbench
================================

# cmd_cfg_param

Parametrised command-configuration block for the quadcopter flight controller. It sits between UART_comm (decoded command/data from the remote link) and the flight controller and inertial integrator. It latches N setpoint channels plus a saturated thrust value, sequences motor spin-up and inertial calibration, and answers each command with ACK/NACK. A communication watchdog forces a safe zero-setpoint state when the link goes quiet. With default parameters, opcodes and behaviour match the existing 3-axis command set.

## Interface
- NUM_SP, 3, number of setpoint channels (≥1); channel i ↔ opcode 0x02+i
- DW, 16, setpoint/data width
- THRST_W, 9, thrust width (≤ DW)
- THRST_MAX, 9'h1FF, thrust saturation ceiling
- SPIN_CYC, 2**26, motor spin-up cycles before calibration starts (≥2)
- WDOG_CYC, 2**27, idle cycles before watchdog trip; 0 disables
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_rdy  in  1  UART_comm has a command pending
- cmd  in  8  opcode
- data  in  DW  command payload
- cal_done  in  1  inertial calibration complete (single-cycle pulse)
- clr_cmd_rdy  out  1  consume pending command (combinational)
- resp  out  8  response byte: 0xA5 ACK, 0xEE NACK
- send_resp  out  1  one-cycle pulse, resp valid
- d_sp  out  NUM_SP*DW  flattened setpoints; channel i = d_sp[i*DW +: DW]
- thrst  out  THRST_W  thrust setpoint
- strt_cal  out  1  one-cycle calibration start pulse
- inertial_cal  out  1  high throughout spin-up and calibration
- motors_off  out  1  motors disabled
- wdog_trip  out  1  sticky watchdog-tripped flag

## Operation
- Opcode map (K = NUM_SP):
  - 0x02..0x01+K: SET_SP[i]
  - 0x02+K: SET_THRST
  - 0x03+K: CAL
  - 0x04+K: EMGL
  - 0x05+K: MOFF
  - any other: NACK
- States: IDLE, SPINUP, CAL.
- IDLE, cmd_rdy=1: clr_cmd_rdy=1 the same cycle. At the next edge, decode and register resp/send_resp, except for CAL.
  - SET_SP[i]: that channel ← data; other channels unchanged; ACK.
  - SET_THRST: thrst ← min(data, THRST_MAX), with the compare done at full DW width; ACK.
  - EMGL: all d_sp ← 0, thrst ← 0; motors_off unchanged; ACK.
  - MOFF: motors_off ← 1; ACK.
  - Unknown opcode: no state change; resp 0xEE, send_resp pulse.
  - CAL: motors_off ← 0, inertial_cal ← 1, spin counter ← 0, go to SPINUP. No response yet.
- SPINUP: counter increments each cycle. When count == SPIN_CYC-1: strt_cal pulse (1 cycle), go to CAL.
- CAL: inertial_cal stays 1 until cal_done. On cal_done: inertial_cal ← 0, resp ← 0xA5 with send_resp pulse, go to IDLE.
- cmd_rdy during SPINUP/CAL: not consumed (clr_cmd_rdy=0). The command stays pending and is decoded in the first IDLE cycle.
- cal_done outside the CAL state is ignored.
- Watchdog (WDOG_CYC≠0):
  - Counter clears on every consumed command and while in SPINUP/CAL; otherwise it increments in IDLE.
  - At WDOG_CYC-1: all d_sp ← 0, thrst ← 0, wdog_trip ← 1, counter holds. motors_off is unchanged.
  - wdog_trip clears on the next consumed command of any opcode, including NACK.
  - If a command is consumed in the same cycle the count reaches terminal, the command wins: no trip, counter clears.

## Timing
- Reset values:
  - state IDLE
  - d_sp 0, thrst 0
  - motors_off 1
  - inertial_cal 0, strt_cal 0
  - send_resp 0, resp 0x00
  - wdog_trip 0
  - counters 0
- Asynchronous reset mid-SPINUP/CAL returns to IDLE immediately with the values above. No response is sent.
- Command latency: cmd_rdy high in cycle n → clr_cmd_rdy high in cycle n → outputs updated and send_resp high in cycle n+1.
  - Back-to-back commands are accepted every cycle.
- CAL latency: consumed in cycle n → inertial_cal high from n+1 → strt_cal high in cycle n+SPIN_CYC → ACK the cycle after the cal_done pulse.
- All outputs except clr_cmd_rdy are registered.

## Test plan
- Defaults. SET_SP opcodes 0x02/0x03/0x04 with 0x0001/0x0002/0x0004 → only the addressed channel changes; each gets an ACK 0xA5 pulse one cycle after clr_cmd_rdy.
- SET_THRST (0x05) with 0x0150 → thrst=0x150. Then with THRST_MAX=9'h100 and data 0x0150 → thrst=0x100. Then data 0xFFFF → thrst=0x100 (no wrap).
- CAL (0x06) with SPIN_CYC=8 → motors_off=0 and inertial_cal=1 next cycle; strt_cal pulse 8 cycles after consume. A SET_SP sent during SPINUP stays pending. cal_done → ACK, then the pending SET_SP is decoded.
- EMGL (0x07) after nonzero setpoints → all d_sp=0 and thrst=0, ACK, motors_off unchanged. MOFF (0x08) → motors_off=1, ACK. Opcode 0x42 → resp 0xEE, no output change.
- NUM_SP=5 build. Opcode 0x06 sets channel 4 at d_sp[79:64]; 0x07 is SET_THRST; 0x0A is MOFF.
- WDOG_CYC=16 with setpoints loaded, idle 16 cycles → d_sp/thrst zeroed and wdog_trip=1. Next command clears wdog_trip. Assert rst_n low mid-CAL → all outputs return to reset values and no ACK is sent.

Source files
------------

// File: rtl/cmd_cfg_param_if.sv
// Command link between the UART decoder (master) and the command-configuration block (slave).
// clr_cmd_rdy is combinational from the slave; resp/send_resp are registered one-cycle responses.
interface cmd_cfg_param_if #(
    parameter int DW = 16
);
    logic          cmd_rdy;
    logic [7:0]    cmd;
    logic [DW-1:0] data;
    logic          clr_cmd_rdy;
    logic [7:0]    resp;
    logic          send_resp;

    modport master (
        output cmd_rdy, cmd, data,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd_rdy, cmd, data,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/cmd_cfg_param.sv
// Latches N setpoints plus saturated thrust, sequences spin-up/calibration, ACK/NACKs commands, link watchdog.
// Latency: command consumed in cycle n (clr_cmd_rdy comb), outputs and response registered at n+1.
// Backpressure: commands are left pending (clr_cmd_rdy low) while spinning up or calibrating.
module cmd_cfg_param #(
    parameter int                 NUM_SP    = 3,
    parameter int                 DW        = 16,
    parameter int                 THRST_W   = 9,
    parameter logic [THRST_W-1:0] THRST_MAX = {THRST_W{1'b1}},
    parameter int                 SPIN_CYC  = 2**26,
    parameter int                 WDOG_CYC  = 2**27
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cmd_cfg_param_if.slave         cmd_if,
    input  logic                   cal_done,
    output logic [NUM_SP*DW-1:0]   d_sp,
    output logic [THRST_W-1:0]     thrst,
    output logic                   strt_cal,
    output logic                   inertial_cal,
    output logic                   motors_off,
    output logic                   wdog_trip
);
    localparam int SCW = $clog2(SPIN_CYC);
    localparam int WCW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

    // strt_cal is registered, so it is launched one count early to land at consume + SPIN_CYC
    localparam logic [SCW-1:0] SPIN_TERM  = SCW'(SPIN_CYC - 2);
    localparam logic [WCW-1:0] WDOG_TERM  = WCW'((WDOG_CYC > 0) ? WDOG_CYC - 1 : 0);
    localparam logic [DW-1:0]  THRST_CEIL = DW'(THRST_MAX);

    localparam logic [7:0] OP_SP0   = 8'h02;
    localparam logic [7:0] OP_THRST = 8'(2 + NUM_SP);
    localparam logic [7:0] OP_CAL   = 8'(3 + NUM_SP);
    localparam logic [7:0] OP_EMGL  = 8'(4 + NUM_SP);
    localparam logic [7:0] OP_MOFF  = 8'(5 + NUM_SP);

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'hEE;

    typedef enum logic [1:0] {ST_IDLE, ST_SPINUP, ST_CAL} state_t;

    state_t                state_q, state_nxt;
    logic [NUM_SP*DW-1:0]  d_sp_nxt;
    logic [THRST_W-1:0]    thrst_nxt;
    logic                  strt_nxt, ical_nxt, moff_nxt, wtrip_nxt;
    logic [7:0]            resp_q, resp_nxt;
    logic                  send_q, send_nxt;
    logic [SCW-1:0]        spin_cnt, spin_nxt;
    logic [WCW-1:0]        wdog_cnt, wdog_nxt;
    logic                  consume;

    always_comb begin
        state_nxt = state_q;
        d_sp_nxt  = d_sp;
        thrst_nxt = thrst;
        strt_nxt  = 1'b0;
        ical_nxt  = inertial_cal;
        moff_nxt  = motors_off;
        wtrip_nxt = wdog_trip;
        resp_nxt  = resp_q;
        send_nxt  = 1'b0;
        spin_nxt  = spin_cnt;
        wdog_nxt  = wdog_cnt;
        consume   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_rdy) begin
                    consume   = 1'b1;
                    wtrip_nxt = 1'b0;
                    wdog_nxt  = '0;
                    send_nxt  = 1'b1;
                    resp_nxt  = RESP_ACK;
                    if (cmd_if.cmd >= OP_SP0 && cmd_if.cmd < OP_THRST) begin
                        for (int i = 0; i < NUM_SP; i++) begin
                            if (cmd_if.cmd == 8'(2 + i)) d_sp_nxt[i*DW +: DW] = cmd_if.data;
                        end
                    end else if (cmd_if.cmd == OP_THRST) begin
                        thrst_nxt = (cmd_if.data > THRST_CEIL) ? THRST_MAX : cmd_if.data[THRST_W-1:0];
                    end else if (cmd_if.cmd == OP_CAL) begin
                        // ACK is deferred until calibration completes
                        send_nxt  = 1'b0;
                        resp_nxt  = resp_q;
                        moff_nxt  = 1'b0;
                        ical_nxt  = 1'b1;
                        spin_nxt  = '0;
                        state_nxt = ST_SPINUP;
                    end else if (cmd_if.cmd == OP_EMGL) begin
                        d_sp_nxt  = '0;
                        thrst_nxt = '0;
                    end else if (cmd_if.cmd == OP_MOFF) begin
                        moff_nxt = 1'b1;
                    end else begin
                        resp_nxt = RESP_NACK;
                    end
                end else if (WDOG_CYC != 0) begin
                    if (wdog_cnt == WDOG_TERM) begin
                        d_sp_nxt  = '0;
                        thrst_nxt = '0;
                        wtrip_nxt = 1'b1;
                    end else begin
                        wdog_nxt = wdog_cnt + 1'b1;
                    end
                end
            end
            ST_SPINUP: begin
                wdog_nxt = '0;
                spin_nxt = spin_cnt + 1'b1;
                if (spin_cnt == SPIN_TERM) begin
                    strt_nxt  = 1'b1;
                    state_nxt = ST_CAL;
                end
            end
            ST_CAL: begin
                wdog_nxt = '0;
                if (cal_done) begin
                    ical_nxt  = 1'b0;
                    resp_nxt  = RESP_ACK;
                    send_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            d_sp         <= '0;
            thrst        <= '0;
            strt_cal     <= 1'b0;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
            wdog_trip    <= 1'b0;
            resp_q       <= 8'h00;
            send_q       <= 1'b0;
            spin_cnt     <= '0;
            wdog_cnt     <= '0;
        end else begin
            state_q      <= state_nxt;
            d_sp         <= d_sp_nxt;
            thrst        <= thrst_nxt;
            strt_cal     <= strt_nxt;
            inertial_cal <= ical_nxt;
            motors_off   <= moff_nxt;
            wdog_trip    <= wtrip_nxt;
            resp_q       <= resp_nxt;
            send_q       <= send_nxt;
            spin_cnt     <= spin_nxt;
            wdog_cnt     <= wdog_nxt;
        end
    end

    assign cmd_if.clr_cmd_rdy = consume;
    assign cmd_if.resp        = resp_q;
    assign cmd_if.send_resp   = send_q;

endmodule

// File: tb/tb_cmd_cfg_param.sv
// Bench for cmd_cfg_param: 3-channel build (random commands vs reference model, calibration)
// and 5-channel build (opcode remap, thrust ceiling, watchdog, reset during calibration).
module tb_cmd_cfg_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n, cal_a, cal_b;
    logic [47:0] dsp_a;
    logic [79:0] dsp_b;
    logic [8:0]  thr_a, thr_b;
    logic        strt_a, ical_a, moff_a, wd_a;
    logic        strt_b, ical_b, moff_b, wd_b;

    cmd_cfg_param_if #(.DW(16)) ia ();
    cmd_cfg_param_if #(.DW(16)) ib ();

    cmd_cfg_param #(.NUM_SP(3), .DW(16), .THRST_W(9), .THRST_MAX(9'h1FF),
                    .SPIN_CYC(8), .WDOG_CYC(0)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .cmd_if(ia), .cal_done(cal_a),
        .d_sp(dsp_a), .thrst(thr_a), .strt_cal(strt_a), .inertial_cal(ical_a),
        .motors_off(moff_a), .wdog_trip(wd_a));

    cmd_cfg_param #(.NUM_SP(5), .DW(16), .THRST_W(9), .THRST_MAX(9'h100),
                    .SPIN_CYC(4), .WDOG_CYC(16)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .cmd_if(ib), .cal_done(cal_b),
        .d_sp(dsp_b), .thrst(thr_b), .strt_cal(strt_b), .inertial_cal(ical_b),
        .motors_off(moff_b), .wdog_trip(wd_b));

    int checks = 0;
    int errors = 0;

    logic [15:0] ma_sp [3];
    logic [8:0]  ma_thr;
    logic        ma_moff;
    logic [15:0] mb_sp [5];
    logic [8:0]  mb_thr;
    logic        mb_moff;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] flat_a();
        logic [47:0] f;
        for (int i = 0; i < 3; i++) f[i*16 +: 16] = ma_sp[i];
        return f;
    endfunction

    function automatic logic [79:0] flat_b();
        logic [79:0] f;
        for (int i = 0; i < 5; i++) f[i*16 +: 16] = mb_sp[i];
        return f;
    endfunction

    task automatic check_state_a(input string tag);
        chk({tag, "_dsp"},  128'(dsp_a),  128'(flat_a()));
        chk({tag, "_thr"},  128'(thr_a),  128'(ma_thr));
        chk({tag, "_moff"}, 128'(moff_a), 128'(ma_moff));
        chk({tag, "_wd"},   128'(wd_a),   128'(0));
    endtask

    task automatic check_state_b(input string tag, input logic exp_wd);
        chk({tag, "_dsp"},  128'(dsp_b),  128'(flat_b()));
        chk({tag, "_thr"},  128'(thr_b),  128'(mb_thr));
        chk({tag, "_moff"}, 128'(moff_b), 128'(mb_moff));
        chk({tag, "_wd"},   128'(wd_b),   128'(exp_wd));
    endtask

    // Issue one non-CAL command on the 3-channel build and check the reply one cycle later.
    task automatic cmd_a(input logic [7:0] op, input logic [15:0] d);
        logic [7:0] er;
        int idx;
        ia.cmd_rdy = 1'b1; ia.cmd = op; ia.data = d;
        #1;
        chk("a_clr", 128'(ia.clr_cmd_rdy), 128'(1));
        er  = 8'hA5;
        idx = int'(op) - 2;
        if (idx >= 0 && idx < 3) ma_sp[idx] = d;
        else if (op == 8'd5) ma_thr = (d > 16'h01FF) ? 9'h1FF : d[8:0];
        else if (op == 8'd7) begin
            for (int i = 0; i < 3; i++) ma_sp[i] = '0;
            ma_thr = '0;
        end
        else if (op == 8'd8) ma_moff = 1'b1;
        else er = 8'hEE;
        tick();
        chk("a_send", 128'(ia.send_resp), 128'(1));
        chk("a_resp", 128'(ia.resp), 128'(er));
        check_state_a("a_cmd");
    endtask

    task automatic cmd_b(input logic [7:0] op, input logic [15:0] d);
        logic [7:0] er;
        int idx;
        ib.cmd_rdy = 1'b1; ib.cmd = op; ib.data = d;
        #1;
        chk("b_clr", 128'(ib.clr_cmd_rdy), 128'(1));
        er  = 8'hA5;
        idx = int'(op) - 2;
        if (idx >= 0 && idx < 5) mb_sp[idx] = d;
        else if (op == 8'd7) mb_thr = (d > 16'h0100) ? 9'h100 : d[8:0];
        else if (op == 8'd9) begin
            for (int i = 0; i < 5; i++) mb_sp[i] = '0;
            mb_thr = '0;
        end
        else if (op == 8'd10) mb_moff = 1'b1;
        else er = 8'hEE;
        tick();
        chk("b_send", 128'(ib.send_resp), 128'(1));
        chk("b_resp", 128'(ib.resp), 128'(er));
        check_state_b("b_cmd", 1'b0);
    endtask

    task automatic idle_a(input int n);
        ia.cmd_rdy = 1'b0;
        repeat (n) begin
            tick();
            chk("a_idle_send", 128'(ia.send_resp), 128'(0));
        end
    endtask

    task automatic check_reset_b(input string tag);
        chk({tag, "_dsp"},  128'(dsp_b),        128'(0));
        chk({tag, "_thr"},  128'(thr_b),        128'(0));
        chk({tag, "_moff"}, 128'(moff_b),       128'(1));
        chk({tag, "_ical"}, 128'(ical_b),       128'(0));
        chk({tag, "_strt"}, 128'(strt_b),       128'(0));
        chk({tag, "_send"}, 128'(ib.send_resp), 128'(0));
        chk({tag, "_resp"}, 128'(ib.resp),      128'(0));
        chk({tag, "_wd"},   128'(wd_b),         128'(0));
    endtask

    initial begin
        logic [7:0]  op;
        logic [15:0] d;
        rst_a_n = 1'b0; rst_b_n = 1'b0; cal_a = 1'b0; cal_b = 1'b0;
        ia.cmd_rdy = 1'b0; ia.cmd = '0; ia.data = '0;
        ib.cmd_rdy = 1'b0; ib.cmd = '0; ib.data = '0;
        for (int i = 0; i < 3; i++) ma_sp[i] = '0;
        for (int i = 0; i < 5; i++) mb_sp[i] = '0;
        ma_thr = '0; ma_moff = 1'b1; mb_thr = '0; mb_moff = 1'b1;

        repeat (2) tick();
        check_state_a("a_rst");
        chk("a_rst_ical", 128'(ical_a), 128'(0));
        chk("a_rst_strt", 128'(strt_a), 128'(0));
        chk("a_rst_resp", 128'(ia.resp), 128'(0));
        check_reset_b("b_rst");
        rst_a_n = 1'b1;
        tick();
        chk("a_idle_clr", 128'(ia.clr_cmd_rdy), 128'(0));
        chk("a_idle_send0", 128'(ia.send_resp), 128'(0));

        // Directed setpoints and thrust, back to back
        cmd_a(8'h02, 16'h0001);
        cmd_a(8'h03, 16'h0002);
        cmd_a(8'h04, 16'h0004);
        cmd_a(8'h05, 16'h0150);
        idle_a(1);

        // Calibration with a SET_SP held pending through spin-up and calibration
        ia.cmd_rdy = 1'b1; ia.cmd = 8'h06; ia.data = '0;
        #1;
        chk("a_cal_clr", 128'(ia.clr_cmd_rdy), 128'(1));
        tick();
        ma_moff = 1'b0;
        chk("a_cal_ical", 128'(ical_a), 128'(1));
        chk("a_cal_moff", 128'(moff_a), 128'(0));
        chk("a_cal_noack", 128'(ia.send_resp), 128'(0));
        chk("a_cal_strt1", 128'(strt_a), 128'(0));
        ia.cmd = 8'h03; ia.data = 16'hCAFE;
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk("a_spin_strt", 128'(strt_a), 128'(k == 8));
            chk("a_spin_clr", 128'(ia.clr_cmd_rdy), 128'(0));
        end
        repeat (2) tick();
        chk("a_cal_strt_done", 128'(strt_a), 128'(0));
        chk("a_cal_hold", 128'(ical_a), 128'(1));
        chk("a_cal_pend", 128'(ia.clr_cmd_rdy), 128'(0));
        cal_a = 1'b1;
        tick();
        cal_a = 1'b0;
        chk("a_caldone_send", 128'(ia.send_resp), 128'(1));
        chk("a_caldone_resp", 128'(ia.resp), 128'(8'hA5));
        chk("a_caldone_ical", 128'(ical_a), 128'(0));
        #1;
        chk("a_pend_clr", 128'(ia.clr_cmd_rdy), 128'(1));
        ma_sp[1] = 16'hCAFE;
        tick();
        chk("a_pend_send", 128'(ia.send_resp), 128'(1));
        chk("a_pend_resp", 128'(ia.resp), 128'(8'hA5));
        check_state_a("a_pend");
        ia.cmd_rdy = 1'b0;

        // Stray cal_done in IDLE
        cal_a = 1'b1;
        tick();
        cal_a = 1'b0;
        chk("a_stray_send", 128'(ia.send_resp), 128'(0));
        chk("a_stray_ical", 128'(ical_a), 128'(0));

        // EMGL keeps motors on, MOFF turns them off, unknown opcode NACKs
        cmd_a(8'h02, 16'h0011);
        cmd_a(8'h07, 16'h1234);
        cmd_a(8'h08, 16'h0000);
        cmd_a(8'h42, 16'h5555);

        // Randomized command stream against the model
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: op = 8'h02;
                1: op = 8'h03;
                2: op = 8'h04;
                3: op = 8'h05;
                4: op = 8'h07;
                5: op = 8'h08;
                default: begin
                    op = 8'($urandom);
                    while (op >= 8'h02 && op <= 8'h08) op = 8'($urandom);
                end
            endcase
            d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            cmd_a(op, d);
            if ($urandom_range(0, 2) == 0) idle_a($urandom_range(1, 3));
        end
        idle_a(1);

        // Five-channel build: opcode remap and lower thrust ceiling
        rst_b_n = 1'b1;
        tick();
        cmd_b(8'h06, 16'hBEEF);
        chk("b_ch4", 128'(dsp_b[79:64]), 128'(16'hBEEF));
        cmd_b(8'h07, 16'h0150);
        cmd_b(8'h07, 16'hFFFF);
        cmd_b(8'h07, 16'h0080);
        cmd_b(8'h09, 16'h0000);
        cmd_b(8'h06, 16'h1234);
        cmd_b(8'h02, 16'h0055);
        cmd_b(8'h07, 16'h00FF);
        cmd_b(8'h0A, 16'h0000);

        // Watchdog: trips WDOG_CYC+1 cycles after the last consumed command
        ib.cmd_rdy = 1'b0;
        repeat (15) tick();
        check_state_b("b_wd_pre", 1'b0);
        tick();
        for (int i = 0; i < 5; i++) mb_sp[i] = '0;
        mb_thr = '0;
        check_state_b("b_wd_trip", 1'b1);
        repeat (3) tick();
        chk("b_wd_sticky", 128'(wd_b), 128'(1));
        cmd_b(8'h42, 16'h0000);

        // Reset in the middle of calibration
        ib.cmd_rdy = 1'b1; ib.cmd = 8'h08; ib.data = '0;
        #1;
        chk("b_cal_clr", 128'(ib.clr_cmd_rdy), 128'(1));
        tick();
        ib.cmd_rdy = 1'b0;
        chk("b_cal_ical", 128'(ical_b), 128'(1));
        chk("b_cal_moff", 128'(moff_b), 128'(0));
        repeat (5) tick();
        chk("b_cal_mid", 128'(ical_b), 128'(1));
        #2;
        rst_b_n = 1'b0;
        #1;
        check_reset_b("b_arst");
        tick();
        rst_b_n = 1'b1;
        cal_b = 1'b1;
        tick();
        cal_b = 1'b0;
        repeat (3) begin
            chk("b_post_send", 128'(ib.send_resp), 128'(0));
            chk("b_post_ical", 128'(ical_b), 128'(0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
